// File: rtl/quad_gen.sv
// Quadrature encoder signal generator: one full A/B detent per accepted step request,
// fixed dwell per quadrature state, with a wrapping signed position count.
//
// state | meaning
// IDLE  | rest at 00, ready for a request
// S1    | first intermediate code (10 CW / 01 CCW)
// S2    | second intermediate code (11)
// S3    | third intermediate code (01 CW / 10 CCW)
// S4    | back at 00, settle dwell before ready
module quad_gen #(
    parameter int PHASE_CYCLES = 50000,
    parameter int POS_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_req,
    input  logic             step_dir,
    output logic             step_rdy,
    output logic             q_a,
    output logic             q_b,
    output logic             edge_stb,
    output logic [POS_W-1:0] pos
);

    localparam int TMR_W = $clog2(PHASE_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PHASE_CYCLES - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S2   = 3'd2;
    localparam logic [2:0] S3   = 3'd3;
    localparam logic [2:0] S4   = 3'd4;

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic             dir;

    // Down-counter dwell: loaded with P-1 on entry, state advances when it reads zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= '0;
            dir      <= 1'b0;
            step_rdy <= 1'b1;
            q_a      <= 1'b0;
            q_b      <= 1'b0;
            edge_stb <= 1'b0;
            pos      <= '0;
        end else begin
            edge_stb <= 1'b0;
            if (state == IDLE) begin
                if (step_req) begin
                    dir      <= step_dir;
                    state    <= S1;
                    timer    <= TMR_LOAD;
                    step_rdy <= 1'b0;
                    q_a      <= step_dir;
                    q_b      <= ~step_dir;
                    edge_stb <= 1'b1;
                end
            end else if (timer != '0) begin
                timer <= timer - TMR_W'(1);
            end else begin
                timer <= TMR_LOAD;
                case (state)
                    S1: begin
                        state    <= S2;
                        q_a      <= 1'b1;
                        q_b      <= 1'b1;
                        edge_stb <= 1'b1;
                    end
                    S2: begin
                        state    <= S3;
                        q_a      <= ~dir;
                        q_b      <= dir;
                        edge_stb <= 1'b1;
                    end
                    S3: begin
                        state    <= S4;
                        q_a      <= 1'b0;
                        q_b      <= 1'b0;
                        edge_stb <= 1'b1;
                        pos      <= dir ? pos + POS_W'(1) : pos - POS_W'(1);
                    end
                    default: begin
                        state    <= IDLE;
                        timer    <= '0;
                        step_rdy <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_quad_gen.sv
// Randomized and directed bench for quad_gen against a detent-offset reference model,
// covering P=4 and P=1 instances.
module tb_quad_gen;

    logic clk = 1'b0;
    logic reset, step_req, step_dir;
    logic rdy4, a4, b4, stb4, rdy1, a1, b1, stb1;
    logic [7:0] pos4, pos1;

    always #5 clk = ~clk;

    quad_gen #(.PHASE_CYCLES(4), .POS_W(8)) dut4 (
        .clk(clk), .reset(reset), .step_req(step_req), .step_dir(step_dir),
        .step_rdy(rdy4), .q_a(a4), .q_b(b4), .edge_stb(stb4), .pos(pos4));

    quad_gen #(.PHASE_CYCLES(1), .POS_W(8)) dut1 (
        .clk(clk), .reset(reset), .step_req(step_req), .step_dir(step_dir),
        .step_rdy(rdy1), .q_a(a1), .q_b(b1), .edge_stb(stb1), .pos(pos1));

    logic       sel;
    logic       s_rdy, s_a, s_b, s_stb;
    logic [7:0] s_pos;
    assign s_rdy = sel ? rdy1 : rdy4;
    assign s_a   = sel ? a1   : a4;
    assign s_b   = sel ? b1   : b4;
    assign s_stb = sel ? stb1 : stb4;
    assign s_pos = sel ? pos1 : pos4;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a detent is "offset k cycles since acceptance"; code = sequence[k/P].
    int         mp = 4;
    logic       busy = 1'b0;
    int         k = 0;
    logic       mdir = 1'b0;
    logic [7:0] mpos = 8'h00;
    logic [1:0] cw_seq  [3] = '{2'b10, 2'b11, 2'b01};
    logic [1:0] ccw_seq [3] = '{2'b01, 2'b11, 2'b10};

    task automatic model_step();
        if (reset) begin
            busy = 1'b0;
            k    = 0;
            mpos = 8'h00;
        end else if (busy) begin
            k++;
            if (k == 3 * mp) mpos = mdir ? mpos + 8'd1 : mpos - 8'd1;
            if (k == 4 * mp) busy = 1'b0;
        end else if (step_req) begin
            busy = 1'b1;
            k    = 0;
            mdir = step_dir;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] eab;
        logic       estb, erdy;
        int         idx;
        if (busy) begin
            idx  = k / mp;
            eab  = (idx < 3) ? (mdir ? cw_seq[idx] : ccw_seq[idx]) : 2'b00;
            estb = (k % mp) == 0;
            erdy = 1'b0;
        end else begin
            eab  = 2'b00;
            estb = 1'b0;
            erdy = 1'b1;
        end
        check_val("ab",  32'({s_a, s_b}), 32'(eab));
        check_val("stb", 32'(s_stb), 32'(estb));
        check_val("rdy", 32'(s_rdy), 32'(erdy));
        check_val("pos", 32'(s_pos), 32'(mpos));
        if (s_stb) ecnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        sel      = 1'b0;
        reset    = 1'b1;
        step_req = 1'b1;
        step_dir = 1'b1;

        // reset held with a pending request
        ticks(3);
        check_val("rst_pos", 32'(s_pos), 32'h0);
        check_val("rst_rdy", 32'(s_rdy), 32'h1);
        reset = 1'b0;

        // single CW step
        step_req = 1'b1; step_dir = 1'b1;
        ecnt = 0;
        tick();
        check_val("cw_first", 32'({s_a, s_b}), 32'h2);
        step_req = 1'b0;
        ticks(20);
        check_val("cw_pos", 32'(s_pos), 32'h01);
        check_val("cw_edges", 32'(ecnt), 32'd4);

        // single CCW from zero
        do_reset();
        step_req = 1'b1; step_dir = 1'b0;
        tick();
        check_val("ccw_first", 32'({s_a, s_b}), 32'h1);
        step_req = 1'b0;
        ticks(20);
        check_val("ccw_pos", 32'(s_pos), 32'hFF);

        // held request, back-to-back detents
        do_reset();
        step_req = 1'b1; step_dir = 1'b1;
        ticks(60);
        step_req = 1'b0;
        ticks(20);
        check_val("held_pos", 32'(s_pos), 32'h04);

        // request and direction change while busy are ignored
        do_reset();
        step_req = 1'b1; step_dir = 1'b1;
        tick();
        step_req = 1'b0;
        ticks(4);
        step_dir = 1'b0; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        ticks(20);
        check_val("busy_pos", 32'(s_pos), 32'h01);

        // reset mid-step in S2
        do_reset();
        step_req = 1'b1; step_dir = 1'b1;
        tick();
        step_req = 1'b0;
        ticks(6);
        check_val("mid_ab", 32'({s_a, s_b}), 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_ab", 32'({s_a, s_b}), 32'h0);
        check_val("mid_rst_rdy", 32'(s_rdy), 32'h1);
        ticks(10);

        // random traffic, P=4
        for (int i = 0; i < 500; i++) begin
            step_req = ($urandom_range(0, 3) == 0);
            step_dir = $urandom_range(0, 1) == 1;
            reset    = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0;

        // switch observation to the P=1 instance
        sel = 1'b1;
        mp  = 1;
        do_reset();
        step_req = 1'b1; step_dir = 1'b1;
        ticks(128 * 5 - 1);
        step_req = 1'b0;
        ticks(6);
        check_val("wrap_pos", 32'(s_pos), 32'h80);

        for (int i = 0; i < 400; i++) begin
            step_req = ($urandom_range(0, 2) != 0);
            step_dir = $urandom_range(0, 1) == 1;
            reset    = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0;
        ticks(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
